// File: rtl/adder_chunked.sv
// Multi-cycle adder: WIDTH-bit a+b+cin computed CHUNK bits per edge (ADDER_CHUNKED_SUB_EN adds a 'sub' port for a-b).
// Latency: out_valid rises NCHUNK edges after accept; issue interval NCHUNK+2 edges.
// Backpressure: result held in DONE until out_ready; in_ready only while IDLE.
module adder_chunked #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDER_CHUNKED_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [CHUNK:0]   chunk_res;

    // Subtraction is folded into the captured operand: a + ~b + 1.
`ifdef ADDER_CHUNKED_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    // Operand registers shift right each BUSY edge, so the active chunk is always at the LSBs.
    assign chunk_res = {1'b0, opa_q[CHUNK-1:0]}
                     + {1'b0, opb_q[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, carry_q};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opa_d   = a;
                    opb_d   = b_eff;
                    carry_d = cin_eff;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d[int'(idx_q)*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
                carry_d = chunk_res[CHUNK];
                opa_d   = opa_q >> CHUNK;
                opb_d   = opb_q >> CHUNK;
                if (idx_q == LAST_IDX) begin
                    sum_d   = acc_d;
                    cout_d  = chunk_res[CHUNK];
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == BUSY);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
